// File: rtl/wb_led_pwm_controller.sv
// Wishbone-controlled LED driver: per-channel static, blink or PWM output,
// all channels sharing one prescaled tick, one PWM counter and one blink phase.
module wb_led_pwm_controller #(
    parameter int          LED_WIDTH      = 4,
    parameter logic [15:0] PRESCALE_RESET = 16'd53
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic                 wbs_rty_o,
    output logic [LED_WIDTH-1:0] led_out
);

    localparam int         MODE_W    = 2 * LED_WIDTH;
    localparam logic [5:0] DUTY_BASE = 6'd8;
    localparam logic [5:0] DUTY_END  = 6'(8 + LED_WIDTH);

    logic [LED_WIDTH-1:0] out_reg;
    logic [MODE_W-1:0]    mode_reg;
    logic [15:0]          prescale_reg;
    logic [15:0]          blink_period_reg;
    logic [7:0]           duty_reg [LED_WIDTH];

    logic [15:0]          presc_cnt_reg;
    logic [7:0]           pwm_cnt_reg;
    logic [15:0]          blink_cnt_reg;
    logic                 blink_phase_reg;

    logic [5:0]           word_sel;
    logic                 req;
    logic                 mapped;
    logic                 bad;
    logic                 wr_en;
    logic                 rd_en;
    logic                 wr_prescale;
    logic                 wr_blink;
    logic                 tick;
    logic                 blink_end;
    logic [31:0]          rd_data;
    logic [31:0]          wmask;
    logic [31:0]          wr_val;
    logic [LED_WIDTH-1:0] led_next;

    assign wbs_rty_o = 1'b0;

    // Only the word offset matters; everything else on the address bus is don't-care.
    assign word_sel = wbs_adr_i[7:2];
    assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & ~wbs_err_o;
    assign mapped   = (word_sel <= 6'd4) || ((word_sel >= DUTY_BASE) && (word_sel < DUTY_END));
    assign bad      = ~mapped | ((word_sel == 6'd4) & wbs_we_i);
    assign wr_en    = req & wbs_we_i & ~bad;
    assign rd_en    = req & ~wbs_we_i & ~bad;

    assign wr_prescale = wr_en && (word_sel == 6'd2);
    assign wr_blink    = wr_en && (word_sel == 6'd3);

    always_comb begin
        rd_data = '0;
        case (word_sel)
            6'd0: rd_data[LED_WIDTH-1:0] = out_reg;
            6'd1: rd_data[MODE_W-1:0]    = mode_reg;
            6'd2: rd_data[15:0]          = prescale_reg;
            6'd3: rd_data[15:0]          = blink_period_reg;
            6'd4: rd_data                = {16'h1ED2, 8'd0, 8'(LED_WIDTH)};
            default: begin
                for (int i = 0; i < LED_WIDTH; i++) begin
                    if (word_sel == DUTY_BASE + 6'(i)) begin
                        rd_data[7:0] = duty_reg[i];
                    end
                end
            end
        endcase
    end

    // Byte-lane merge against the current contents; rd_data is already zero above each width.
    assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wr_val = (rd_data & ~wmask) | (wbs_dat_i & wmask);

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0], wr_val[31:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req & ~bad;
            wbs_err_o <= req & bad;
            wbs_dat_o <= rd_en ? rd_data : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg          <= '0;
            mode_reg         <= '0;
            prescale_reg     <= PRESCALE_RESET;
            blink_period_reg <= '0;
            for (int i = 0; i < LED_WIDTH; i++) begin
                duty_reg[i] <= '0;
            end
        end else if (wr_en) begin
            case (word_sel)
                6'd0: out_reg          <= wr_val[LED_WIDTH-1:0];
                6'd1: mode_reg         <= wr_val[MODE_W-1:0];
                6'd2: prescale_reg     <= wr_val[15:0];
                6'd3: blink_period_reg <= wr_val[15:0];
                default: begin
                    for (int i = 0; i < LED_WIDTH; i++) begin
                        if (word_sel == DUTY_BASE + 6'(i)) begin
                            duty_reg[i] <= wr_val[7:0];
                        end
                    end
                end
            endcase
        end
    end

    assign tick      = (presc_cnt_reg == prescale_reg);
    assign blink_end = (blink_cnt_reg == blink_period_reg - 16'd1);

    // A register write coinciding with a tick still lets the counters advance on that tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_reg   <= '0;
            pwm_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
        end else begin
            if (wr_prescale || tick) begin
                presc_cnt_reg <= '0;
            end else begin
                presc_cnt_reg <= presc_cnt_reg + 16'd1;
            end

            if (tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            end

            if (wr_blink) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= 1'b1;
            end else if (tick && (blink_period_reg != 16'd0)) begin
                if (blink_end) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 16'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < LED_WIDTH; gi++) begin : g_led
        logic [1:0] ch_mode;
        assign ch_mode = mode_reg[2*gi +: 2];
        // Reserved mode 11 falls through to static.
        assign led_next[gi] = (ch_mode == 2'b01) ? (out_reg[gi] & blink_phase_reg) :
                              (ch_mode == 2'b10) ? (pwm_cnt_reg < duty_reg[gi]) :
                                                   out_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_next;
        end
    end

endmodule

// File: tb/tb_wb_led_pwm_controller.sv
// Randomized and directed bench for wb_led_pwm_controller against a register-level
// reference model plus run-length / duty-count checks on the LED outputs.
module tb_wb_led_pwm_controller;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = '0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_cyc_i = 1'b0;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic          wbs_err_o;
    logic          wbs_rty_o;
    logic [LW-1:0] led_out;

    wb_led_pwm_controller #(.LED_WIDTH(LW), .PRESCALE_RESET(16'd53)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbs_rty_o (wbs_rty_o),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference register file
    logic [LW-1:0]   m_out;
    logic [2*LW-1:0] m_mode;
    logic [15:0]     m_presc;
    logic [15:0]     m_blink;
    logic [7:0]      m_duty [LW];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out   = '0;
        m_mode  = '0;
        m_presc = 16'd53;
        m_blink = '0;
        for (int i = 0; i < LW; i++) m_duty[i] = '0;
    endtask

    function automatic logic m_bad(input int w, input logic we);
        logic mapped;
        mapped = (w <= 4) || (w >= 8 && w < 8 + LW);
        return !mapped || (w == 4 && we);
    endfunction

    function automatic logic [31:0] m_read(input int w);
        logic [31:0] r;
        r = 32'h0;
        if (w == 0) r = 32'(m_out);
        else if (w == 1) r = 32'(m_mode);
        else if (w == 2) r = 32'(m_presc);
        else if (w == 3) r = 32'(m_blink);
        else if (w == 4) r = {16'h1ED2, 8'd0, 8'(LW)};
        else if (w >= 8 && w < 8 + LW) r = 32'(m_duty[w-8]);
        return r;
    endfunction

    task automatic m_write(input int w, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] mask;
        logic [31:0] v;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = sel[b] ? 8'hFF : 8'h00;
        v = (m_read(w) & ~mask) | (dat & mask);
        if (w == 0) m_out = v[LW-1:0];
        else if (w == 1) m_mode = v[2*LW-1:0];
        else if (w == 2) m_presc = v[15:0];
        else if (w == 3) m_blink = v[15:0];
        else if (w >= 8 && w < 8 + LW) m_duty[w-8] = v[7:0];
    endtask

    // One Wishbone access, checked against the model; returns one clk after the response.
    task automatic do_txn(input logic we, input int w, input logic [31:0] dat, input logic [3:0] sel);
        logic        exp_bad;
        logic [31:0] exp_rd;
        logic [31:0] rdat;
        logic        got_ack;
        logic        got_err;
        int          waited;
        exp_bad = m_bad(w, we);
        exp_rd  = (we || exp_bad) ? 32'h0 : m_read(w);
        @(posedge clk); #1;
        wbs_adr_i = {24'($urandom), 6'(w), 2'($urandom)};
        wbs_dat_i = dat;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!(wbs_ack_o || wbs_err_o) && waited < 8);
        got_ack = wbs_ack_o;
        got_err = wbs_err_o;
        rdat    = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        check_eq($sformatf("latency w%0d", w), 32'(waited), 32'd1);
        check_eq($sformatf("ack w%0d", w), 32'(got_ack), 32'(!exp_bad));
        check_eq($sformatf("err w%0d", w), 32'(got_err), 32'(exp_bad));
        if (!we) check_eq($sformatf("rdata w%0d", w), rdat, exp_rd);
        if (we && !exp_bad) m_write(w, dat, sel);
        @(posedge clk); #1;
        check_eq($sformatf("one_cycle w%0d", w), 32'(wbs_ack_o | wbs_err_o), 32'd0);
        $display("txn %s off=0x%02h dat=%h sel=%b ack=%0d err=%0d rdata=%h",
                 we ? "WR" : "RD", 8'(w * 4), dat, sel, got_ack, got_err, rdat);
    endtask

    task automatic wr(input int w, input logic [31:0] dat);
        do_txn(1'b1, w, dat, 4'hF);
    endtask

    task automatic check_all_regs();
        for (int w = 0; w <= 4; w++) do_txn(1'b0, w, 32'h0, 4'hF);
        for (int i = 0; i < LW; i++) do_txn(1'b0, 8 + i, 32'h0, 4'hF);
    endtask

    // Clocks until led_out[ch] changes value, bounded by lim.
    task automatic run_len(input int ch, input int lim, output int n);
        logic v;
        v = led_out[ch];
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (led_out[ch] == v && n < lim);
    endtask

    task automatic count_high(input int ch, input int ncyc, output int hi);
        hi = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            hi += int'(led_out[ch]);
        end
    endtask

    task automatic blink_check(input int period);
        int n;
        wr(2, 32'd0);
        wr(3, 32'(period));
        wr(0, 32'h1);
        wr(1, 32'h01);
        run_len(0, 2 * period + 6, n);
        check_eq("blink_first_edge", 32'(n <= 2 * period + 4), 32'd1);
        for (int k = 0; k < 2; k++) begin
            run_len(0, 4 * period, n);
            check_eq($sformatf("blink_run p%0d", period), 32'(n), 32'(period));
            check_eq("blink_others", 32'(led_out[LW-1:1]), 32'd0);
        end
    endtask

    task automatic pwm_check(input int duty, input int presc);
        int hi;
        wr(1, 32'h08);
        wr(2, 32'(presc));
        wr(9, 32'(duty));
        count_high(1, 256 * (presc + 1), hi);
        check_eq($sformatf("pwm_high d%0d p%0d", duty, presc), 32'(hi), 32'(duty * (presc + 1)));
    endtask

    initial begin
        int w;
        int n;
        logic we;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_led", 32'(led_out), 32'd0);
        check_eq("rst_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst_err", 32'(wbs_err_o), 32'd0);
        check_eq("rst_dat", wbs_dat_o, 32'd0);
        check_eq("rty", 32'(wbs_rty_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check_all_regs();

        // Static output, readback and INFO
        wr(1, 32'h0);
        wr(0, 32'h0F);
        check_eq("static_led", 32'(led_out), 32'hF);
        do_txn(1'b0, 0, 32'h0, 4'hF);
        check_eq("info_const", m_read(4), 32'h1ED20004);
        do_txn(1'b0, 4, 32'h0, 4'hF);

        // Random register traffic incl. unmapped offsets and partial byte enables
        for (int t = 0; t < 40; t++) begin
            w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 11));
            we = 1'($urandom);
            do_txn(we, w, $urandom, 4'($urandom));
        end
        check_all_regs();

        // Error accesses leave state intact
        do_txn(1'b0, 15, 32'h0, 4'hF);
        do_txn(1'b1, 4, 32'hFFFF_FFFF, 4'hF);
        do_txn(1'b1, 6, 32'hFFFF_FFFF, 4'hF);
        check_all_regs();

        // Byte-lane gating on PRESCALE
        wr(2, 32'h0);
        do_txn(1'b1, 2, 32'h1234_5678, 4'b0001);
        do_txn(1'b0, 2, 32'h0, 4'hF);
        check_eq("presc_sel_model", m_read(2), 32'h0000_0078);

        blink_check(4);
        for (int k = 0; k < 2; k++) blink_check(int'($urandom_range(2, 9)));

        pwm_check(64, 0);
        pwm_check(0, 0);
        pwm_check(255, 0);
        pwm_check(int'($urandom_range(1, 254)), 0);
        pwm_check(128, 3);

        // Asynchronous reset during blink
        wr(2, 32'h0);
        wr(3, 32'd1000);
        wr(0, 32'hF);
        wr(1, 32'h55);
        repeat (2) @(posedge clk);
        #1;
        check_eq("pre_reset_led", 32'(led_out), 32'hF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", 32'(led_out), 32'd0);
        check_eq("async_rst_dat", wbs_dat_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all_regs();
        run_len(0, 8, n);
        check_eq("post_reset_led", 32'(led_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
